// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for a single register-file write port, with read-hazard snoop and collision flag.
// Optional REGFILE_WRARB_FIXED_PRIO_EN selects fixed priority (A over B) instead of round-robin.
module regfile_write_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              Reset_n,
  input  logic              ReqA,
  input  logic              ReqB,
  input  logic [ADDR_W-1:0] AddrA,
  input  logic [ADDR_W-1:0] AddrB,
  input  logic [DATA_W-1:0] DataA,
  input  logic [DATA_W-1:0] DataB,
  output logic              ReadyA,
  output logic              ReadyB,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  output logic              Hazard1,
  output logic              Hazard2,
  output logic              Collision
);

  logic grant_a;
  logic grant_b;
  logic transfer;

`ifdef REGFILE_WRARB_FIXED_PRIO_EN
  always_comb begin
    grant_a = Reset_n && ReqA;
    grant_b = Reset_n && ReqB && !ReqA;
  end
`else
  // last_grant: 1 = B won the most recent transfer, so A wins the next contention.
  logic last_grant;

  always_comb begin
    grant_a = Reset_n && ReqA && (!ReqB || last_grant);
    grant_b = Reset_n && ReqB && !grant_a;
  end

  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      last_grant <= 1'b1;
    end else if (grant_a || grant_b) begin
      last_grant <= grant_b;
    end
  end
`endif

  assign ReadyA   = grant_a;
  assign ReadyB   = grant_b;
  assign transfer = grant_a || grant_b;

  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
      Collision <= 1'b0;
    end else begin
      RegWrite  <= transfer;
      Collision <= ReqA && ReqB && (AddrA == AddrB);
      if (grant_a) begin
        WriteReg  <= AddrA;
        WriteData <= DataA;
      end else if (grant_b) begin
        WriteReg  <= AddrB;
        WriteData <= DataB;
      end
    end
  end

  // Snoop: a read of the register being written this cycle sees stale file contents.
  assign Hazard1 = RegWrite && (Read1 == WriteReg);
  assign Hazard2 = RegWrite && (Read2 == WriteReg);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Vector table plus randomized requesters checked against a behavioural arbitration model.
module tb_regfile_write_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;
`ifdef REGFILE_WRARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          Reset_n = 1'b0;
  logic          ReqA = 1'b0, ReqB = 1'b0;
  logic [AW-1:0] AddrA = '0, AddrB = '0, Read1 = '0, Read2 = '0;
  logic [DW-1:0] DataA = '0, DataB = '0;
  logic          ReadyA, ReadyB, RegWrite, Hazard1, Hazard2, Collision;
  logic [AW-1:0] WriteReg;
  logic [DW-1:0] WriteData;

  regfile_write_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .Reset_n(Reset_n),
    .ReqA(ReqA), .ReqB(ReqB), .AddrA(AddrA), .AddrB(AddrB),
    .DataA(DataA), .DataB(DataB), .ReadyA(ReadyA), .ReadyB(ReadyB),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .Read1(Read1), .Read2(Read2), .Hazard1(Hazard1), .Hazard2(Hazard2),
    .Collision(Collision)
  );

  always #5 clock = ~clock;

  // Register file image built from committed writes.
  logic [DW-1:0] rf [0:63];
  initial for (int i = 0; i < 64; i++) rf[i] = '0;
  always @(posedge clock) if (Reset_n && RegWrite) rf[WriteReg] <= WriteData;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          ra, rb;
    logic [AW-1:0] aa, ab;
    logic [DW-1:0] da, db;
    logic [AW-1:0] r1, r2;
    logic          ya, yb, rw;
    logic [AW-1:0] wr;
    logic [DW-1:0] wd;
    logic          col, h1, h2;
  } vec_t;

  function automatic vec_t mk(logic ra, logic rb, int aa, int ab, int da, int db, int r1, int r2,
                              logic ya, logic yb, logic rw, int wr, int wd,
                              logic col, logic h1, logic h2);
    vec_t v;
    v.ra = ra; v.rb = rb; v.aa = AW'(aa); v.ab = AW'(ab); v.da = DW'(da); v.db = DW'(db);
    v.r1 = AW'(r1); v.r2 = AW'(r2); v.ya = ya; v.yb = yb; v.rw = rw;
    v.wr = AW'(wr); v.wd = DW'(wd); v.col = col; v.h1 = h1; v.h2 = h2;
    return v;
  endfunction

  vec_t tbl [13];

  // Behavioural model state for the random phase.
  logic          m_last_b, m_rw, m_coll;
  logic [AW-1:0] m_wreg;
  logic [DW-1:0] m_wdata;
  logic          pa, pb, ga, gb;

  initial begin
    // Rows: inputs applied after a falling edge; registered expectations reflect the previous row.
    tbl[0]  = mk(0,0, 0,0, 0,0,       0,0, 0,0, 0, 0,0,      0,0,0);
    tbl[1]  = mk(1,0, 1,0, 12,0,      1,0, 1,0, 0, 0,0,      0,0,0);
    tbl[2]  = mk(0,0, 0,0, 0,0,       1,0, 0,0, 1, 1,12,     0,1,0);
    tbl[3]  = mk(0,1, 0,7, 0,'h77,    1,0, 0,1, 0, 1,12,     0,0,0);
    tbl[4]  = mk(1,1, 2,3, 'h22,'h33, 0,0, 1,0, 1, 7,'h77,   0,0,0);
    tbl[5]  = mk(1,1, 2,3, 'h22,'h33, 0,0, FIXED,!FIXED, 1, 2,'h22, 0,0,0);
    tbl[6]  = mk(1,1, 2,3, 'h22,'h33, 0,0, 1,0, 1, FIXED ? 2 : 3, FIXED ? 'h22 : 'h33, 0,0,0);
    tbl[7]  = mk(1,1, 2,3, 'h22,'h33, 0,0, FIXED,!FIXED, 1, 2,'h22, 0,0,0);
    tbl[8]  = mk(1,1, 5,5, 256,123,   0,0, 1,0, 1, FIXED ? 2 : 3, FIXED ? 'h22 : 'h33, 0,0,0);
    tbl[9]  = mk(0,1, 0,5, 0,123,     0,0, 0,1, 1, 5,256,    1,0,0);
    tbl[10] = mk(1,0, 4,0, 'h44,0,    5,5, 1,0, 1, 5,123,    0,1,1);
    tbl[11] = mk(0,0, 0,0, 0,0,       4,0, 0,0, 1, 4,'h44,   0,1,0);
    tbl[12] = mk(0,0, 0,0, 0,0,       4,0, 0,0, 0, 4,'h44,   0,0,0);

    // Reset: outputs cleared and no grant even with a request present.
    ReqA = 1'b1; ReqB = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_readya", ReadyA, 0);
    chk("rst_readyb", ReadyB, 0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_collision", Collision, 0);
    ReqA = 1'b0; ReqB = 1'b0;
    @(negedge clock);
    Reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      ReqA = tbl[i].ra; ReqB = tbl[i].rb; AddrA = tbl[i].aa; AddrB = tbl[i].ab;
      DataA = tbl[i].da; DataB = tbl[i].db; Read1 = tbl[i].r1; Read2 = tbl[i].r2;
      #1;
      chk($sformatf("v%0d_readya", i), ReadyA, tbl[i].ya);
      chk($sformatf("v%0d_readyb", i), ReadyB, tbl[i].yb);
      chk($sformatf("v%0d_regwrite", i), RegWrite, tbl[i].rw);
      chk($sformatf("v%0d_writereg", i), WriteReg, tbl[i].wr);
      chk($sformatf("v%0d_writedata", i), WriteData, tbl[i].wd);
      chk($sformatf("v%0d_collision", i), Collision, tbl[i].col);
      chk($sformatf("v%0d_hazard1", i), Hazard1, tbl[i].h1);
      chk($sformatf("v%0d_hazard2", i), Hazard2, tbl[i].h2);
    end
    chk("rf_reg5_last_write_wins", rf[5], FIXED ? 123 : 123);
    chk("rf_reg4", rf[4], 'h44);
    chk("rf_reg1", rf[1], 12);

    // Asynchronous reset in the middle of a RegWrite cycle.
    @(negedge clock);
    ReqA = 1'b1; AddrA = 9; DataA = 'h99;
    @(posedge clock);
    #2;
    chk("midrst_pre_regwrite", RegWrite, 1);
    Reset_n = 1'b0;
    #1;
    chk("midrst_regwrite", RegWrite, 0);
    chk("midrst_writereg", WriteReg, 0);
    chk("midrst_writedata", WriteData, 0);
    chk("midrst_readya", ReadyA, 0);
    @(negedge clock);
    ReqA = 1'b0;
    @(negedge clock);
    // Release with contention: A must win and be accepted on the first edge.
    Reset_n = 1'b1;
    ReqA = 1'b1; ReqB = 1'b1; AddrA = 10; AddrB = 11; DataA = 'hA0; DataB = 'hB0;
    #1;
    chk("rel_regwrite", RegWrite, 0);
    chk("rel_readya", ReadyA, 1);
    chk("rel_readyb", ReadyB, 0);
    @(negedge clock);
    ReqA = 1'b0;
    #1;
    chk("rel_first_regwrite", RegWrite, 1);
    chk("rel_first_writereg", WriteReg, 10);
    chk("rel_b_next", ReadyB, 1);
    @(negedge clock);
    ReqB = 1'b0;
    #1;
    chk("rel_second_writereg", WriteReg, 11);
    chk("rf_reg9_discarded", rf[9], 0);

    // Randomized phase from a fresh reset.
    @(negedge clock);
    Reset_n = 1'b0;
    @(negedge clock);
    Reset_n = 1'b1;
    m_last_b = 1'b1; m_rw = 1'b0; m_coll = 1'b0; m_wreg = '0; m_wdata = '0;
    pa = 1'b0; pb = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (!pa && $urandom_range(0, 1) == 1) begin
        pa = 1'b1; AddrA = AW'($urandom_range(0, 7)); DataA = $urandom;
      end
      if (!pb && $urandom_range(0, 1) == 1) begin
        pb = 1'b1; AddrB = AW'($urandom_range(0, 7)); DataB = $urandom;
      end
      ReqA = pa; ReqB = pb;
      Read1 = AW'($urandom_range(0, 7)); Read2 = AW'($urandom_range(0, 7));
      #1;
      // A requester wins if alone, or if contending and B was granted more recently.
      ga = pa && (FIXED || !pb || m_last_b);
      gb = pb && !ga;
      chk("rnd_readya", ReadyA, ga);
      chk("rnd_readyb", ReadyB, gb);
      chk("rnd_regwrite", RegWrite, m_rw);
      chk("rnd_writereg", WriteReg, m_wreg);
      chk("rnd_writedata", WriteData, m_wdata);
      chk("rnd_collision", Collision, m_coll);
      chk("rnd_hazard1", Hazard1, m_rw && (Read1 == m_wreg));
      chk("rnd_hazard2", Hazard2, m_rw && (Read2 == m_wreg));
      m_coll = pa && pb && (AddrA == AddrB);
      m_rw = ga || gb;
      if (ga) begin
        m_wreg = AddrA; m_wdata = DataA; m_last_b = 1'b0; pa = 1'b0;
      end else if (gb) begin
        m_wreg = AddrB; m_wdata = DataB; m_last_b = 1'b1; pb = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, meaning register address width; it matches the register file WriteReg/Read1/Read2 width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning write data width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; the ports follow.
REQ-004 The block SHALL have port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port: Reset_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have ports: ReqA, ReqB  input  1  requester A (ALU writeback) and requester B (load return) write requests.
REQ-007 The block SHALL have ports: AddrA, AddrB  input  ADDR_W  target register per requester.
REQ-008 The block SHALL have ports: DataA, DataB  input  DATA_W  write data per requester.
REQ-009 The block SHALL have ports: ReadyA, ReadyB  output  1  grant; a transfer occurs when Req and Ready are both high at a clock edge.
REQ-010 The block SHALL have ports: WriteReg  output  ADDR_W, WriteData  output  DATA_W, RegWrite  output  1; all registered, driving the register file write port.
REQ-011 The block SHALL have ports: Read1, Read2  input  ADDR_W  register file read addresses, snooped.
REQ-012 The block SHALL have ports: Hazard1, Hazard2  output  1  read address matches an uncommitted write.
REQ-013 The block SHALL have port: Collision  output  1  registered pulse; both requesters targeted the same address in one cycle.

Function
REQ-014 ReadyA/ReadyB SHALL be combinational from ReqA, ReqB and the priority state; at most one SHALL be high per cycle, and Ready SHALL be low for a requester whose Req is low.
REQ-015 With a single requester active, that requester SHALL be granted the same cycle.
REQ-016 With both active, the requester not granted last SHALL win (round-robin); a 1-bit LastGrant register SHALL update only on a transfer.
REQ-017 A transfer at edge t SHALL load WriteReg/WriteData from the winner and set RegWrite=1 for cycle t..t+1; the register file commits at edge t+1 (latency 1 to RegWrite, 2 to committed data).
REQ-018 With no transfer at an edge, RegWrite SHALL be 0 for the following cycle; WriteReg/WriteData SHALL hold their values.
REQ-019 Back-to-back transfers SHALL be sustained at one per cycle with no bubble.
REQ-020 Hazard1 SHALL equal RegWrite && (Read1 == WriteReg); Hazard2 SHALL be the same with Read2; both combinational.
REQ-021 When ReqA, ReqB are both high and AddrA == AddrB, Collision SHALL be 1 in the next cycle; the loser SHALL still be serviced later, so the later write wins in the register file.
REQ-022 Address 0 SHALL receive no special treatment; writes to it pass through.
REQ-023 A requester SHALL hold Req, Addr and Data stable until granted; the block SHALL not buffer ungranted requests.

Reset
REQ-024 Assertion of Reset_n low SHALL immediately force RegWrite=0, WriteReg=0, WriteData=0, Collision=0, and LastGrant=B, so A wins the first contention.
REQ-025 During reset, ReadyA and ReadyB SHALL be 0; a reset asserted mid-transfer SHALL discard the pending write, with no RegWrite after release.
REQ-026 After release, the first transfer SHALL be accepted at the first rising edge with Reset_n high.

Configuration
REQ-027 When macro REGFILE_WRARB_FIXED_PRIO_EN is defined, arbitration SHALL be fixed priority: A always beats B, and LastGrant SHALL be absent; otherwise round-robin per REQ-016 applies.

Verification
REQ-028 Reset then ReqA=1, AddrA=1, DataA=12 for one cycle -> ReadyA=1 that cycle; next cycle RegWrite=1, WriteReg=1, WriteData=12; then RegWrite=0.
REQ-029 ReqA, ReqB held high for 4 cycles (AddrA=2, AddrB=3) -> grants A,B,A,B; RegWrite continuous; WriteReg sequence 2,3,2,3 (macro undefined); with macro defined -> A,A,A,A.
REQ-030 ReqA=ReqB=1, AddrA=AddrB=5, DataA=256, DataB=123 -> Collision=1 one cycle after; writes issued 256 then 123; register 5 finally holds 123.
REQ-031 Write to reg 4 issued; during the RegWrite cycle Read1=4, Read2=0 -> Hazard1=1, Hazard2=0; one cycle later Hazard1=0.
REQ-032 Reset_n pulled low asynchronously between clock edges while RegWrite=1 -> RegWrite=0 immediately; Ready=0 while low; no write after release.
